// File: rtl/asrm_bus_ctrl.sv
// CPU-to-byte-RAM bridge: splits a word/half/byte access into sequential byte
// cycles on an 8-bit RAM port and returns a one-cycle cpu_ready pulse.
module asrm_bus_ctrl #(
  parameter int unsigned wordsize = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_wdata,
  input  logic                cpu_we,
  input  logic [1:0]          cpu_size,
  output logic [wordsize-1:0] cpu_rdata,
  output logic                cpu_ready,
  output logic                mem_en,
  output logic                mem_we,
  output logic [wordsize-1:0] mem_addr,
  output logic [7:0]          mem_wdata,
  input  logic [7:0]          mem_rdata
);

  localparam int unsigned NB = wordsize / 8;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t              state, state_nxt;
  logic [wordsize-1:0] base_q;
  logic [wordsize-1:0] wdata_q;
  logic [wordsize-1:0] wdata_sh;
  logic [3:0]          n_q;
  logic [3:0]          k_q;
  logic [3:0]          n_req;

  always_comb begin
    n_req = 4'd1;
    unique case (cpu_size)
      2'b00:   n_req = 4'(NB);
      2'b01:   n_req = (NB < 4) ? 4'(NB) : 4'd4;
      2'b10:   n_req = (NB < 2) ? 4'(NB) : 4'd2;
      default: n_req = 4'd1;
    endcase
  end

  assign wdata_sh = wdata_q >> {k_q, 3'b000};

  // READ runs for N+1 cycles: k=0..N-1 issue, k=1..N capture the previous byte.
  always_comb begin
    state_nxt = state;
    cpu_ready = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = base_q + wordsize'(k_q);
    mem_wdata = wdata_sh[7:0];
    unique case (state)
      IDLE: begin
        if (cpu_req) state_nxt = cpu_we ? WRITE : READ;
      end
      WRITE: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
        if (k_q == n_q - 4'd1) state_nxt = DONE;
      end
      READ: begin
        if (k_q < n_q) mem_en = 1'b1;
        if (k_q == n_q) state_nxt = DONE;
      end
      DONE: begin
        cpu_ready = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      base_q    <= '0;
      wdata_q   <= '0;
      n_q       <= '0;
      k_q       <= '0;
      cpu_rdata <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            base_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            n_q     <= n_req;
            k_q     <= '0;
            if (!cpu_we) begin
              for (int unsigned i = 0; i < NB; i++) begin
                if (4'(i) >= n_req) cpu_rdata[i*8 +: 8] <= '0;
              end
            end
          end
        end
        WRITE: k_q <= k_q + 4'd1;
        READ: begin
          k_q <= k_q + 4'd1;
          if (k_q != '0) begin
            for (int unsigned i = 0; i < NB; i++) begin
              if (4'(i) == k_q - 4'd1) cpu_rdata[i*8 +: 8] <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
